// File: rtl/mem_word_adapter.sv
// Adapts 32-bit word reads and writes to a 16-bit-per-location memory.
// Each word becomes two sequential accesses: hi half first (big-endian).
module mem_word_adapter #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned HALF_SIZE    = 16,
  parameter int unsigned MEM_DEPTH    = 5001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_SIZE-1:0]   cpu_addr,
  input  logic [2*HALF_SIZE-1:0]    cpu_wdata,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  output logic [2*HALF_SIZE-1:0]    cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_err,
  output logic                      cpu_busy,
  output logic [ADDRESS_SIZE-1:0]   mem_addr,
  output logic [HALF_SIZE-1:0]      mem_wdata,
  output logic                      mem_read,
  output logic                      mem_write,
  input  logic [HALF_SIZE-1:0]      mem_rdata
);

  typedef enum logic [3:0] {
    StIdle,
    StRdHiA,
    StRdHiB,
    StRdLoA,
    StRdLoB,
    StWrHi,
    StWrLo,
    StDone,
    StErr
  } state_e;

  localparam logic [ADDRESS_SIZE-1:0] LastBase = ADDRESS_SIZE'(MEM_DEPTH - 1);

  state_e                    state_q, state_d;
  logic [ADDRESS_SIZE-1:0]   base_q;
  logic [2*HALF_SIZE-1:0]    wdata_q;
  logic [2*HALF_SIZE-1:0]    rdata_q;
  logic [HALF_SIZE-1:0]      hi_q;

  logic [ADDRESS_SIZE-1:0]   req_base;
  logic [ADDRESS_SIZE-1:0]   lo_addr;
  logic                      req_err;

  assign req_base = cpu_addr >> 1;
  assign lo_addr  = base_q + ADDRESS_SIZE'(1);
  // The lo half lives at base+1, so base itself must stay below the last location.
  assign req_err  = (cpu_addr[1:0] != 2'b00) || (req_base >= LastBase);

  assign cpu_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && cpu_req) begin
        base_q  <= req_base;
        wdata_q <= cpu_wdata;
      end
      if (state_q == StRdHiB) hi_q <= mem_rdata;
      if (state_q == StRdLoB) rdata_q <= {hi_q, mem_rdata};
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (req_err)     state_d = StErr;
          else if (cpu_we) state_d = StWrHi;
          else             state_d = StRdHiA;
        end
      end
      StRdHiA: begin
        mem_read = 1'b1;
        mem_addr = base_q;
        state_d  = StRdHiB;
      end
      StRdHiB: begin
        mem_read = 1'b1;
        mem_addr = base_q;
        state_d  = StRdLoA;
      end
      StRdLoA: begin
        mem_read = 1'b1;
        mem_addr = lo_addr;
        state_d  = StRdLoB;
      end
      StRdLoB: begin
        mem_read = 1'b1;
        mem_addr = lo_addr;
        state_d  = StDone;
      end
      StWrHi: begin
        mem_write = 1'b1;
        mem_addr  = base_q;
        mem_wdata = wdata_q[2*HALF_SIZE-1:HALF_SIZE];
        state_d   = StWrLo;
      end
      StWrLo: begin
        mem_write = 1'b1;
        mem_addr  = lo_addr;
        mem_wdata = wdata_q[HALF_SIZE-1:0];
        state_d   = StDone;
      end
      StDone: begin
        cpu_ready = 1'b1;
        state_d   = StIdle;
      end
      StErr: begin
        cpu_ready = 1'b1;
        cpu_err   = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    cpu_busy = (state_q != StIdle);

    // Quiet all outputs while reset is asserted so an aborted write cannot
    // commit its current half at the reset edge.
    if (!rst) begin
      cpu_ready = 1'b0;
      cpu_err   = 1'b0;
      cpu_busy  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule
